// File: rtl/ecc_bus_pkg.sv
// ecc_bus_pkg: shared FSM encoding and datapath/counter widths for the ECC bus arbiter.
package ecc_bus_pkg;
   localparam int DATA_W = 32;
   localparam int CNT_W = 16;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first set request at or after ptr; one-hot grant and its index.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IW = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IW-1:0]      idx
);
   always_comb begin
      idx = ptr;
      // Scan farthest-first so the candidate closest to ptr is the last one written.
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (req[(int'(ptr) + k) % NUM_REQ]) idx = IW'((int'(ptr) + k) % NUM_REQ);
      grant = (req != '0) ? (NUM_REQ'(1) << idx) : '0;
   end
endmodule

// File: rtl/ecc_bus_arbiter.sv
// ecc_bus_arbiter: round-robin single-outstanding transfer arbiter over an ECC-protected bus.
// Define ECC_RETRY_EN to reissue uncorrectable returns up to MAX_RETRY times.
module ecc_bus_arbiter
   import ecc_bus_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 8,
   parameter int MAX_RETRY = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [DATA_W*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      bus_valid_out,
   output logic [DATA_W-1:0]         bus_data_out,
   input  logic                      bus_valid_in,
   input  logic [DATA_W-1:0]         bus_data_in,
   input  logic                      bus_err_det,
   input  logic                      bus_err_corr,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_err,
   output logic [CNT_W-1:0]          corr_count,
   output logic [CNT_W-1:0]          uncorr_count
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int WW = $clog2(TIMEOUT + 1);

   state_t            state, state_nx;
   logic [IW-1:0]     rr_ptr, owner, win_idx;
   logic [NUM_REQ-1:0] win_grant;
   logic [DATA_W-1:0] word, win_word;
   logic [WW-1:0]     wait_cnt;
   logic              take, ret, tmo, bad, fix, retry;

   assign bad  = bus_err_det & ~bus_err_corr;
   assign fix  = bus_err_det & bus_err_corr;
   assign take = (state == IDLE) && (req_valid != '0);
   assign ret  = (state == WAIT) && bus_valid_in;
   assign tmo  = (state == WAIT) && !bus_valid_in && (wait_cnt == WW'(TIMEOUT - 1));

`ifdef ECC_RETRY_EN
   localparam int RW = $clog2(MAX_RETRY + 2);
   logic [RW-1:0] retry_cnt;
   assign retry = ret && bad && (retry_cnt < RW'(MAX_RETRY));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) retry_cnt <= '0;
      else if (state == IDLE) retry_cnt <= '0;
      else if (retry) retry_cnt <= retry_cnt + 1'b1;
`else
   logic unused_max_retry;
   assign unused_max_retry = MAX_RETRY > 0;
   assign retry = 1'b0;
`endif

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req(req_valid),
      .ptr(rr_ptr),
      .grant(win_grant),
      .idx(win_idx)
   );

   always_comb begin
      win_word = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (win_idx == IW'(i)) win_word = req_data[DATA_W*i +: DATA_W];
   end

   always_comb
      state_nx = take ? ISSUE : (state == ISSUE) ? WAIT : retry ? ISSUE : (ret || tmo) ? IDLE : state;

   // Gated by rst_n so a pending request cannot leak a ready pulse while reset is held.
   assign req_ready     = (take && rst_n) ? win_grant : '0;
   assign bus_valid_out = (state == ISSUE);
   assign bus_data_out  = bus_valid_out ? word : '0;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         owner        <= '0;
         word         <= '0;
         wait_cnt     <= '0;
         rsp_valid    <= '0;
         rsp_data     <= '0;
         rsp_err      <= 1'b0;
         corr_count   <= '0;
         uncorr_count <= '0;
      end else begin
         state     <= state_nx;
         rsp_valid <= '0;
         wait_cnt  <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
         if (take) begin
            rr_ptr <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            owner  <= win_idx;
            word   <= win_word;
         end
         if ((ret && !retry) || tmo) begin
            rsp_valid <= NUM_REQ'(1) << owner;
            rsp_data  <= tmo ? '0 : bus_data_in;
            rsp_err   <= tmo | bad;
         end
         if (ret && fix && corr_count != '1) corr_count <= corr_count + 1'b1;
         if (ret && bad && !retry && uncorr_count != '1) uncorr_count <= uncorr_count + 1'b1;
      end
endmodule

// File: doc/ecc_bus_arbiter.md
ECC_BUS_ARBITER -- requirements
Module: ecc_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 8, maximum cycles WAIT holds before abandoning a transfer.
REQ-003 SHALL have parameter MAX_RETRY, default 2, maximum reissues per transfer when retry is compiled in.
REQ-004 SHALL have port clk, input, 1, the single system clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ, per-requester request pending.
REQ-007 SHALL have port req_data, input, 32*NUM_REQ, flattened request words; requester i occupies bits [32i+31:32i].
REQ-008 SHALL have port req_ready, output, NUM_REQ, one-hot accept pulse to the granted requester.
REQ-009 SHALL have port bus_valid_out, output, 1, word launched into the ECC-protected bus interface.
REQ-010 SHALL have port bus_data_out, output, 32, word launched.
REQ-011 SHALL have ports bus_valid_in, bus_data_in[31:0], bus_err_det, bus_err_corr, input, returned word and ECC flags from the bus interface.
REQ-012 SHALL have ports rsp_valid[NUM_REQ-1:0] (output, one-hot), rsp_data[31:0] (output), and rsp_err (output, 1), the response to the owning requester.
REQ-013 SHALL have ports corr_count[15:0] and uncorr_count[15:0], output, saturating ECC event counters.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT.
REQ-015 IDLE: when any req_valid is set, SHALL grant round-robin starting at pointer rr_ptr, pulse req_ready[winner] for one cycle, latch word and owner, go to ISSUE.
REQ-016 SHALL advance rr_ptr to (winner+1) mod NUM_REQ on each grant; rr_ptr SHALL be unchanged when no request is pending.
REQ-017 ISSUE: SHALL assert bus_valid_out for exactly one cycle with the latched word on bus_data_out, clear the wait counter, and go to WAIT.
REQ-018 WAIT: on bus_valid_in SHALL register bus_data_in into rsp_data and pulse rsp_valid[owner] the next cycle, with rsp_err = bus_err_det & ~bus_err_corr.
REQ-019 An uncorrectable word is bus_err_det=1 with bus_err_corr=0; a corrected word is bus_err_det=1 with bus_err_corr=1.
REQ-020 A corrected word SHALL increment corr_count; a final uncorrectable word SHALL increment uncorr_count; both counters SHALL saturate at 16'hFFFF.
REQ-021 If WAIT lasts TIMEOUT cycles without bus_valid_in, SHALL pulse rsp_valid[owner] with rsp_err=1 and rsp_data=0, then go to IDLE; timeouts SHALL NOT touch the counters.
REQ-022 bus_valid_in while in IDLE or ISSUE SHALL be ignored.
REQ-023 Minimum turnaround SHALL be 4 cycles: grant, issue, bus return, response.
REQ-024 Exactly one transfer SHALL be outstanding; req_ready SHALL stay 0 outside IDLE.
REQ-025 A requester dropping req_valid before its grant SHALL lose no state; its bit is simply not considered.

Reset
REQ-026 While rst_n=0, SHALL force state=IDLE, rr_ptr=0, retry count=0, and both counters to 0.
REQ-027 While rst_n=0, SHALL force req_ready=0, bus_valid_out=0, bus_data_out=0, rsp_valid=0, rsp_data=0, and rsp_err=0.
REQ-028 Reset during ISSUE or WAIT SHALL abandon the transfer with no response pulse.

Configuration
REQ-029 With ECC_RETRY_EN defined: an uncorrectable return while retry count < MAX_RETRY SHALL return to ISSUE, increment retry count, emit no response and leave uncorr_count unchanged; it SHALL respond with rsp_err=1 only once retries are exhausted.
REQ-030 Without ECC_RETRY_EN: the first uncorrectable return SHALL be reported immediately; no retry logic or counter SHALL exist.

Structure
REQ-031 State enum, counter width (16), and data width (32) SHALL live in shared package ecc_bus_pkg.
REQ-032 Round-robin selection SHALL be sub-module rr_arbiter (request vector, pointer in; one-hot grant and index out).

Verification
REQ-033 Single req_valid=4'b0001, word 32'hDEADBEEF, clean return -> rsp_valid=4'b0001, rsp_data=32'hDEADBEEF, rsp_err=0, 4 cycles after grant.
REQ-034 req_valid=4'b1111 held for 4 transfers from reset -> grant order 0,1,2,3; then rr_ptr=0.
REQ-035 Return with err_det=1 and err_corr=1 -> rsp_err=0 and corr_count 0->1; force counter at 16'hFFFF and repeat -> stays 16'hFFFF.
REQ-036 Uncorrectable return each time: with ECC_RETRY_EN -> 3 bus_valid_out pulses, then rsp_err=1 and uncorr_count=1; without it -> 1 pulse, rsp_err=1.
REQ-037 No bus_valid_in after issue -> rsp_err=1 and rsp_data=0 after 8 WAIT cycles, state returns to IDLE.
REQ-038 rst_n low mid-WAIT -> all outputs 0, no rsp_valid pulse, next grant to requester 0.
